// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and width limit.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MAX_WIDTH = 16;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle between the board top level and the subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  ready, busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, diff, borrow_out
    );
endinterface

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin with borrow out.
module full_subtractor (
    input  logic x_i,
    input  logic y_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);
    assign d_o    = x_i ^ y_i ^ bin_i;
    assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell reused every RUN cycle.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic cell_d;
    logic cell_bout;

    full_subtractor u_cell (
        .x_i    (a_sr_q[0]),
        .y_i    (b_sr_q[0]),
        .bin_i  (borrow_q),
        .d_o    (cell_d),
        .bout_o (cell_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sr_d   = bus.a;
                    b_sr_d   = bus.b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_d    = {cell_d, res_q[WIDTH-1:1]};
                borrow_d = cell_bout;
                cnt_d    = cnt_q + 1'b1;
                // The final bit lands in res_d on this same edge, so publish res_d, not res_q.
                if (cnt_q == LAST_CNT) begin
                    diff_d  = res_d;
                    bout_d  = cell_bout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    assign bus.ready      = (state_q == IDLE);
    assign bus.busy       = (state_q == RUN);
    assign bus.done       = (state_q == DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=2 and WIDTH=4, plus a full WIDTH=4 operand sweep.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(2)) if2 ();
    serial_subtractor_if #(.WIDTH(4)) if4 ();

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run2(input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] ed, input logic eb);
        if2.start = 1'b1;
        if2.a     = a;
        if2.b     = b;
        tick();
        if2.start = 1'b0;
        if2.a     = ~a;
        if2.b     = ~b;
        chk("w2_busy", 32'(if2.busy), 32'd1);
        tick();
        chk("w2_done_early", 32'(if2.done), 32'd0);
        tick();
        chk("w2_done", 32'(if2.done), 32'd1);
        chk("w2_diff", 32'(if2.diff), 32'(ed));
        chk("w2_borrow", 32'(if2.borrow_out), 32'(eb));
        tick();
        chk("w2_ready_back", 32'(if2.ready), 32'd1);
        chk("w2_diff_held", 32'(if2.diff), 32'(ed));
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ed, input logic eb);
        if4.start = 1'b1;
        if4.a     = a;
        if4.b     = b;
        tick();
        if4.start = 1'b0;
        if4.a     = ~a;
        if4.b     = ~b;
        chk("w4_busy", 32'(if4.busy), 32'd1);
        chk("w4_not_ready", 32'(if4.ready), 32'd0);
        repeat (3) tick();
        chk("w4_done_early", 32'(if4.done), 32'd0);
        tick();
        chk("w4_done", 32'(if4.done), 32'd1);
        chk("w4_diff", 32'(if4.diff), 32'(ed));
        chk("w4_borrow", 32'(if4.borrow_out), 32'(eb));
        chk("w4_busy_off", 32'(if4.busy), 32'd0);
        tick();
        chk("w4_ready_back", 32'(if4.ready), 32'd1);
        chk("w4_done_pulse", 32'(if4.done), 32'd0);
        chk("w4_diff_held", 32'(if4.diff), 32'(ed));
    endtask

    initial begin
        logic [4:0] ref5;

        if2.start = 1'b0;
        if2.a     = '0;
        if2.b     = '0;
        if4.start = 1'b0;
        if4.a     = '0;
        if4.b     = '0;

        // Reset state
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_ready", 32'(if4.ready), 32'd1);
        chk("rst_busy", 32'(if4.busy), 32'd0);
        chk("rst_done", 32'(if4.done), 32'd0);
        chk("rst_diff", 32'(if4.diff), 32'd0);
        chk("rst_borrow", 32'(if4.borrow_out), 32'd0);
        chk("rst_ready2", 32'(if2.ready), 32'd1);
        chk("rst_diff2", 32'(if2.diff), 32'd0);

        // WIDTH=2 directed
        run2(2'd3, 2'd1, 2'b10, 1'b0);
        run2(2'd1, 2'd2, 2'b11, 1'b1);
        run2(2'd0, 2'd0, 2'b00, 1'b0);

        // WIDTH=4: restarts during RUN/DONE ignored, operand changes after capture ignored
        if4.start = 1'b1;
        if4.a     = 4'd9;
        if4.b     = 4'd4;
        tick();
        if4.a = 4'd1;
        if4.b = 4'd1;
        tick();
        chk("rerun_busy", 32'(if4.busy), 32'd1);
        if4.start = 1'b0;
        if4.a     = 4'hF;
        if4.b     = 4'hF;
        tick();
        tick();
        tick();
        chk("rerun_done", 32'(if4.done), 32'd1);
        chk("rerun_diff", 32'(if4.diff), 32'd5);
        chk("rerun_borrow", 32'(if4.borrow_out), 32'd0);
        if4.start = 1'b1;
        if4.a     = 4'd1;
        if4.b     = 4'd1;
        tick();
        if4.start = 1'b0;
        chk("rerun_idle", 32'(if4.ready), 32'd1);
        chk("rerun_held", 32'(if4.diff), 32'd5);
        tick();
        chk("rerun_no_run", 32'(if4.busy), 32'd0);

        // WIDTH=4 directed
        run4(4'hA, 4'h3, 4'h7, 1'b0);
        run4(4'h0, 4'h1, 4'hF, 1'b1);

        // Reset on the second RUN cycle discards the operation and clears results
        if4.start = 1'b1;
        if4.a     = 4'd5;
        if4.b     = 4'd2;
        tick();
        if4.start = 1'b0;
        tick();
        chk("mid_busy", 32'(if4.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_ready", 32'(if4.ready), 32'd1);
        chk("mid_diff", 32'(if4.diff), 32'd0);
        chk("mid_borrow", 32'(if4.borrow_out), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mid_no_done", 32'(if4.done), 32'd0);
        end
        run4(4'd5, 4'd2, 4'd3, 1'b0);

        // Simultaneous rst and start: start dropped
        rst       = 1'b1;
        if4.start = 1'b1;
        if4.a     = 4'd7;
        if4.b     = 4'd1;
        tick();
        rst       = 1'b0;
        if4.start = 1'b0;
        chk("rs_ready", 32'(if4.ready), 32'd1);
        chk("rs_busy", 32'(if4.busy), 32'd0);
        tick();
        chk("rs_still_idle", 32'(if4.ready), 32'd1);

        // Exhaustive WIDTH=4 sweep against a 5-bit reference subtraction
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                ref5 = {1'b0, 4'(ia)} - {1'b0, 4'(ib)};
                run4(4'(ia), 4'(ib), ref5[3:0], ref5[4]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
